// File: rtl/tick_rate_decoder_if.sv
// Bundles the tick stream, clear and decoded-rate status between a rate decoder and its user.
// The master side drives tick_in/clr; the slave side (the decoder) drives the status outputs.
interface tick_rate_decoder_if #(
  parameter int CNT_W = 27
);
  logic             tick_in;
  logic             clr;
  logic [CNT_W-1:0] period_o;
  logic [2:0]       speed_o;
  logic             valid_o;
  logic             err_o;
  logic             lock_o;
  logic             timeout_o;

  modport master (
    output tick_in,
    output clr,
    input  period_o,
    input  speed_o,
    input  valid_o,
    input  err_o,
    input  lock_o,
    input  timeout_o
  );

  modport slave (
    input  tick_in,
    input  clr,
    output period_o,
    output speed_o,
    output valid_o,
    output err_o,
    output lock_o,
    output timeout_o
  );
endinterface

// File: rtl/tick_rate_decoder.sv
// Recovers the 3-bit speed code from a clock-enable tick stream by measuring the clk
// distance between ticks and matching it against the prescaler's period table.
//
// state   | meaning
// IDLE    | no window open; the next tick starts a measurement
// MEASURE | counting clk cycles since the last tick
// TIMEOUT | no tick for TIMEOUT_CYC cycles; the next tick reopens a window
module tick_rate_decoder #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int CNT_W       = 27,
  parameter int TOL         = 0,
  parameter int TIMEOUT_CYC = 75_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tick_rate_decoder_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W:0]   TOL_V  = (CNT_W+1)'(TOL);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [2:0]       speed_q, speed_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             lock_q, lock_d;
  logic             timeout_q, timeout_d;
  logic             cand_vld_q, cand_vld_d;
  logic [2:0]       cand_code_q, cand_code_d;

  logic             hit;
  logic [2:0]       hit_code;

  function automatic logic [CNT_W:0] exp_period(input logic [2:0] code);
    logic [CNT_W:0] p;
    case (code)
      3'd0:    p = (CNT_W+1)'(1);
      3'd1:    p = (CNT_W+1)'(CLK_HZ / 50);
      3'd2:    p = (CNT_W+1)'(CLK_HZ / 20);
      3'd3:    p = (CNT_W+1)'(CLK_HZ / 10);
      3'd4:    p = (CNT_W+1)'(CLK_HZ / 5);
      3'd5:    p = (CNT_W+1)'(CLK_HZ / 2);
      3'd6:    p = (CNT_W+1)'(CLK_HZ);
      default: p = '0;
    endcase
    return p;
  endfunction

  // Scan from the top down so the lowest matching code is the one left standing.
  always_comb begin
    logic [CNT_W:0] cnt_ext;
    logic [CNT_W:0] exp_p;
    logic [CNT_W:0] diff;
    hit      = 1'b0;
    hit_code = 3'd0;
    cnt_ext  = {1'b0, cnt_q};
    for (int i = 6; i >= 0; i--) begin
      exp_p = exp_period(3'(i));
      diff  = (cnt_ext >= exp_p) ? (cnt_ext - exp_p) : (exp_p - cnt_ext);
      if (diff <= TOL_V) begin
        hit      = 1'b1;
        hit_code = 3'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    speed_d     = speed_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    lock_d      = lock_q;
    timeout_d   = timeout_q;
    cand_vld_d  = cand_vld_q;
    cand_code_d = cand_code_q;

    if (bus.clr) begin
      state_d    = IDLE;
      cnt_d      = '0;
      lock_d     = 1'b0;
      timeout_d  = 1'b0;
      cand_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.tick_in) begin
            state_d = MEASURE;
            cnt_d   = ONE;
          end
        end
        MEASURE: begin
          if (bus.tick_in) begin
            cnt_d    = ONE;
            period_d = cnt_q;
            if (hit) begin
              speed_d     = hit_code;
              valid_d     = 1'b1;
              lock_d      = cand_vld_q && (cand_code_q == hit_code);
              cand_vld_d  = 1'b1;
              cand_code_d = hit_code;
            end else begin
              err_d      = 1'b1;
              lock_d     = 1'b0;
              cand_vld_d = 1'b0;
            end
          end else begin
            // cnt stops at TO_CNT: the state leaves MEASURE on the same edge it gets there.
            cnt_d = cnt_q + ONE;
            if (cnt_d >= TO_CNT) begin
              cnt_d      = TO_CNT;
              state_d    = TIMEOUT;
              timeout_d  = 1'b1;
              lock_d     = 1'b0;
              cand_vld_d = 1'b0;
            end
          end
        end
        TIMEOUT: begin
          if (bus.tick_in) begin
            state_d   = MEASURE;
            cnt_d     = ONE;
            timeout_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      speed_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      lock_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cand_vld_q  <= 1'b0;
      cand_code_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      speed_q     <= speed_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      lock_q      <= lock_d;
      timeout_q   <= timeout_d;
      cand_vld_q  <= cand_vld_d;
      cand_code_q <= cand_code_d;
    end
  end

  assign bus.period_o  = period_q;
  assign bus.speed_o   = speed_q;
  assign bus.valid_o   = valid_q;
  assign bus.err_o     = err_q;
  assign bus.lock_o    = lock_q;
  assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_tick_rate_decoder.sv
// Directed bench for tick_rate_decoder: two instances (TOL=0 and TOL=2) share one tick
// stream; inputs change and outputs are sampled on the falling edge.
module tb_tick_rate_decoder;
  localparam int CNT_W = 11;

  logic clk;
  logic rst_n;
  logic tick;
  logic clr;

  int n_cmp;
  int n_bad;
  int seen_v0;
  int seen_e0;

  tick_rate_decoder_if #(.CNT_W(CNT_W)) if0 ();
  tick_rate_decoder_if #(.CNT_W(CNT_W)) if2 ();

  assign if0.tick_in = tick;
  assign if0.clr     = clr;
  assign if2.tick_in = tick;
  assign if2.clr     = clr;

  tick_rate_decoder #(.CLK_HZ(1000), .CNT_W(CNT_W), .TOL(0), .TIMEOUT_CYC(1500)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  tick_rate_decoder #(.CLK_HZ(1000), .CNT_W(CNT_W), .TOL(2), .TIMEOUT_CYC(1500)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    if (if0.valid_o) seen_v0++;
    if (if0.err_o) seen_e0++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick  = 1'b0;
    clr   = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (if0.period_o !== 11'd0) begin n_bad++; $display("FAIL reset_period got=%0d exp=0", if0.period_o); end
    n_cmp++; if (if0.speed_o !== 3'd0) begin n_bad++; $display("FAIL reset_speed got=%0d exp=0", if0.speed_o); end
    n_cmp++; if ({if0.valid_o, if0.err_o, if0.lock_o, if0.timeout_o} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=0000", {if0.valid_o, if0.err_o, if0.lock_o, if0.timeout_o});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_period_100();
    send_tick();
    n_cmp++; if (if0.valid_o !== 1'b0) begin n_bad++; $display("FAIL p100_open_valid got=%b exp=0", if0.valid_o); end
    idle(99);
    send_tick();
    n_cmp++; if (if0.valid_o !== 1'b1) begin n_bad++; $display("FAIL p100_t2_valid got=%b exp=1", if0.valid_o); end
    n_cmp++; if (if0.period_o !== 11'd100) begin n_bad++; $display("FAIL p100_t2_period got=%0d exp=100", if0.period_o); end
    n_cmp++; if (if0.speed_o !== 3'd3) begin n_bad++; $display("FAIL p100_t2_speed got=%0d exp=3", if0.speed_o); end
    n_cmp++; if (if0.lock_o !== 1'b0) begin n_bad++; $display("FAIL p100_t2_lock got=%b exp=0", if0.lock_o); end
    idle(99);
    send_tick();
    n_cmp++; if (if0.valid_o !== 1'b1) begin n_bad++; $display("FAIL p100_t3_valid got=%b exp=1", if0.valid_o); end
    n_cmp++; if (if0.lock_o !== 1'b1) begin n_bad++; $display("FAIL p100_t3_lock got=%b exp=1", if0.lock_o); end
    step();
    n_cmp++; if (if0.valid_o !== 1'b0) begin n_bad++; $display("FAIL p100_pulse_width got=%b exp=0", if0.valid_o); end
  endtask

  task automatic test_code0_burst();
    logic [4:0] exp_v;
    logic [4:0] exp_l;
    exp_v = 5'b11110;
    exp_l = 5'b11100;
    do_clr();
    seen_v0 = 0;
    tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (if0.valid_o !== exp_v[i]) begin n_bad++; $display("FAIL burst_valid[%0d] got=%b exp=%b", i, if0.valid_o, exp_v[i]); end
      n_cmp++; if (if0.lock_o !== exp_l[i]) begin n_bad++; $display("FAIL burst_lock[%0d] got=%b exp=%b", i, if0.lock_o, exp_l[i]); end
    end
    tick = 1'b0;
    n_cmp++; if (if0.period_o !== 11'd1) begin n_bad++; $display("FAIL burst_period got=%0d exp=1", if0.period_o); end
    n_cmp++; if (if0.speed_o !== 3'd0) begin n_bad++; $display("FAIL burst_speed got=%0d exp=0", if0.speed_o); end
    step();
    n_cmp++; if (seen_v0 !== 4) begin n_bad++; $display("FAIL burst_valid_count got=%0d exp=4", seen_v0); end
  endtask

  task automatic test_mismatch();
    do_clr();
    send_tick();
    idle(99);
    send_tick();
    n_cmp++; if (if0.speed_o !== 3'd3) begin n_bad++; $display("FAIL mm_pre_speed got=%0d exp=3", if0.speed_o); end
    seen_e0 = 0;
    idle(72);
    send_tick();
    n_cmp++; if (if0.err_o !== 1'b1) begin n_bad++; $display("FAIL mm_err got=%b exp=1", if0.err_o); end
    n_cmp++; if (if0.valid_o !== 1'b0) begin n_bad++; $display("FAIL mm_valid got=%b exp=0", if0.valid_o); end
    n_cmp++; if (if0.period_o !== 11'd73) begin n_bad++; $display("FAIL mm_period got=%0d exp=73", if0.period_o); end
    n_cmp++; if (if0.speed_o !== 3'd3) begin n_bad++; $display("FAIL mm_speed_hold got=%0d exp=3", if0.speed_o); end
    n_cmp++; if (if0.lock_o !== 1'b0) begin n_bad++; $display("FAIL mm_lock got=%b exp=0", if0.lock_o); end
    step();
    n_cmp++; if (seen_e0 !== 1) begin n_bad++; $display("FAIL mm_err_count got=%0d exp=1", seen_e0); end
    // 102 lies inside the TOL=2 window around 100 but outside the exact one.
    do_clr();
    send_tick();
    idle(101);
    send_tick();
    n_cmp++; if (if2.valid_o !== 1'b1) begin n_bad++; $display("FAIL tol2_valid got=%b exp=1", if2.valid_o); end
    n_cmp++; if (if2.speed_o !== 3'd3) begin n_bad++; $display("FAIL tol2_speed got=%0d exp=3", if2.speed_o); end
    n_cmp++; if (if2.period_o !== 11'd102) begin n_bad++; $display("FAIL tol2_period got=%0d exp=102", if2.period_o); end
    n_cmp++; if (if0.err_o !== 1'b1) begin n_bad++; $display("FAIL tol0_102_err got=%b exp=1", if0.err_o); end
  endtask

  task automatic test_timeout();
    do_clr();
    send_tick();
    idle(99);
    send_tick();
    idle(1498);
    n_cmp++; if (if0.timeout_o !== 1'b0) begin n_bad++; $display("FAIL to_early got=%b exp=0", if0.timeout_o); end
    step();
    n_cmp++; if (if0.timeout_o !== 1'b1) begin n_bad++; $display("FAIL to_set got=%b exp=1", if0.timeout_o); end
    n_cmp++; if (if0.lock_o !== 1'b0) begin n_bad++; $display("FAIL to_lock got=%b exp=0", if0.lock_o); end
    idle(20);
    n_cmp++; if (if0.timeout_o !== 1'b1) begin n_bad++; $display("FAIL to_level got=%b exp=1", if0.timeout_o); end
    send_tick();
    n_cmp++; if (if0.timeout_o !== 1'b0) begin n_bad++; $display("FAIL to_clear got=%b exp=0", if0.timeout_o); end
    n_cmp++; if ({if0.valid_o, if0.err_o} !== 2'b00) begin n_bad++; $display("FAIL to_reopen_pulse got=%b exp=00", {if0.valid_o, if0.err_o}); end
    idle(999);
    send_tick();
    n_cmp++; if (if0.valid_o !== 1'b1) begin n_bad++; $display("FAIL to_1000_valid got=%b exp=1", if0.valid_o); end
    n_cmp++; if (if0.speed_o !== 3'd6) begin n_bad++; $display("FAIL to_1000_speed got=%0d exp=6", if0.speed_o); end
    n_cmp++; if (if0.period_o !== 11'd1000) begin n_bad++; $display("FAIL to_1000_period got=%0d exp=1000", if0.period_o); end
  endtask

  task automatic test_clr_with_tick();
    do_clr();
    send_tick();
    idle(49);
    send_tick();
    idle(49);
    send_tick();
    n_cmp++; if (if0.lock_o !== 1'b1) begin n_bad++; $display("FAIL clr_prelock got=%b exp=1", if0.lock_o); end
    n_cmp++; if (if0.speed_o !== 3'd2) begin n_bad++; $display("FAIL clr_prespeed got=%0d exp=2", if0.speed_o); end
    idle(49);
    seen_v0 = 0;
    clr  = 1'b1;
    tick = 1'b1;
    step();
    clr  = 1'b0;
    tick = 1'b0;
    n_cmp++; if (if0.lock_o !== 1'b0) begin n_bad++; $display("FAIL clr_lock got=%b exp=0", if0.lock_o); end
    n_cmp++; if (if0.valid_o !== 1'b0) begin n_bad++; $display("FAIL clr_valid got=%b exp=0", if0.valid_o); end
    n_cmp++; if (if0.period_o !== 11'd50) begin n_bad++; $display("FAIL clr_period_hold got=%0d exp=50", if0.period_o); end
    idle(20);
    send_tick();
    n_cmp++; if (if0.valid_o !== 1'b0) begin n_bad++; $display("FAIL clr_open_valid got=%b exp=0", if0.valid_o); end
    idle(49);
    send_tick();
    n_cmp++; if (if0.speed_o !== 3'd2) begin n_bad++; $display("FAIL clr_after_speed got=%0d exp=2", if0.speed_o); end
    n_cmp++; if (if0.lock_o !== 1'b0) begin n_bad++; $display("FAIL clr_after_lock got=%b exp=0", if0.lock_o); end
    step();
    n_cmp++; if (seen_v0 !== 1) begin n_bad++; $display("FAIL clr_valid_count got=%0d exp=1", seen_v0); end
  endtask

  task automatic test_reset_mid();
    do_clr();
    send_tick();
    idle(39);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (if0.period_o !== 11'd0) begin n_bad++; $display("FAIL rmid_period got=%0d exp=0", if0.period_o); end
    n_cmp++; if (if0.speed_o !== 3'd0) begin n_bad++; $display("FAIL rmid_speed got=%0d exp=0", if0.speed_o); end
    step();
    rst_n = 1'b1;
    step();
    seen_v0 = 0;
    send_tick();
    n_cmp++; if (if0.valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_first_valid got=%b exp=0", if0.valid_o); end
    idle(99);
    send_tick();
    n_cmp++; if (if0.valid_o !== 1'b1) begin n_bad++; $display("FAIL rmid_second_valid got=%b exp=1", if0.valid_o); end
    n_cmp++; if (seen_v0 !== 1) begin n_bad++; $display("FAIL rmid_valid_count got=%0d exp=1", seen_v0); end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    seen_v0 = 0;
    seen_e0 = 0;
    test_reset();
    test_period_100();
    test_code0_burst();
    test_mismatch();
    test_timeout();
    test_clr_with_tick();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
